// File: rtl/gte_instr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// GTEDefine
// Shared definitions for the GTE instruction front-end.
//   CTRL            decoded COP2 flag fields (sf, mx, v, cv, lm)
//   gteComputeCtrl  one micro-op word sent to the compute path each cycle
//   gteEntry        entry-table record {valid, start address, step count}
//   seqState_e      sequencer FSM states
// Also holds the funct codes, the per-instruction cycle counts, the entry
// table lookup and the generator for the microcode image.
// ---------------------------------------------------------------------------
package GTEDefine;

   localparam int ENTRY_AW = 9;
   localparam int COUNT_W  = 6;

   localparam logic [5:0] OP_RTPS  = 6'h01;
   localparam logic [5:0] OP_NCLIP = 6'h06;
   localparam logic [5:0] OP_OP    = 6'h0C;
   localparam logic [5:0] OP_DPCS  = 6'h10;
   localparam logic [5:0] OP_INTPL = 6'h11;
   localparam logic [5:0] OP_MVMVA = 6'h12;
   localparam logic [5:0] OP_NCDS  = 6'h13;
   localparam logic [5:0] OP_CDP   = 6'h14;
   localparam logic [5:0] OP_NCDT  = 6'h16;
   localparam logic [5:0] OP_NCCS  = 6'h1B;
   localparam logic [5:0] OP_CC    = 6'h1C;
   localparam logic [5:0] OP_NCS   = 6'h1E;
   localparam logic [5:0] OP_NCT   = 6'h20;
   localparam logic [5:0] OP_SQR   = 6'h28;
   localparam logic [5:0] OP_DCPL  = 6'h29;
   localparam logic [5:0] OP_DPCT  = 6'h2A;
   localparam logic [5:0] OP_AVSZ3 = 6'h2D;
   localparam logic [5:0] OP_AVSZ4 = 6'h2E;
   localparam logic [5:0] OP_RTPT  = 6'h30;
   localparam logic [5:0] OP_GPF   = 6'h3D;
   localparam logic [5:0] OP_GPL   = 6'h3E;
   localparam logic [5:0] OP_NCCT  = 6'h3F;

   localparam logic [COUNT_W-1:0] CYC_RTPS  = 6'd15;
   localparam logic [COUNT_W-1:0] CYC_NCLIP = 6'd8;
   localparam logic [COUNT_W-1:0] CYC_OP    = 6'd6;
   localparam logic [COUNT_W-1:0] CYC_DPCS  = 6'd8;
   localparam logic [COUNT_W-1:0] CYC_INTPL = 6'd8;
   localparam logic [COUNT_W-1:0] CYC_MVMVA = 6'd8;
   localparam logic [COUNT_W-1:0] CYC_NCDS  = 6'd19;
   localparam logic [COUNT_W-1:0] CYC_CDP   = 6'd13;
   localparam logic [COUNT_W-1:0] CYC_NCDT  = 6'd44;
   localparam logic [COUNT_W-1:0] CYC_NCCS  = 6'd17;
   localparam logic [COUNT_W-1:0] CYC_CC    = 6'd11;
   localparam logic [COUNT_W-1:0] CYC_NCS   = 6'd14;
   localparam logic [COUNT_W-1:0] CYC_NCT   = 6'd30;
   localparam logic [COUNT_W-1:0] CYC_SQR   = 6'd5;
   localparam logic [COUNT_W-1:0] CYC_DCPL  = 6'd8;
   localparam logic [COUNT_W-1:0] CYC_DPCT  = 6'd17;
   localparam logic [COUNT_W-1:0] CYC_AVSZ3 = 6'd5;
   localparam logic [COUNT_W-1:0] CYC_AVSZ4 = 6'd6;
   localparam logic [COUNT_W-1:0] CYC_RTPT  = 6'd23;
   localparam logic [COUNT_W-1:0] CYC_GPF   = 6'd5;
   localparam logic [COUNT_W-1:0] CYC_GPL   = 6'd5;
   localparam logic [COUNT_W-1:0] CYC_NCCT  = 6'd39;

   // Address 0 of the image is kept all-zero so unsupported functs can
   // simply "execute" one step from there and emit a NOP.
   localparam logic [ENTRY_AW-1:0] NOP_ADDR = '0;

   typedef struct packed {
      logic       sf;
      logic [1:0] mx;
      logic [1:0] v;
      logic [1:0] cv;
      logic       lm;
   } CTRL;

   typedef struct packed {
      logic       valid;
      logic [5:0] funct;
      logic [5:0] step;
      logic       finalOp;
   } gteComputeCtrl;

   typedef struct packed {
      logic                valid;
      logic [ENTRY_AW-1:0] start;
      logic [COUNT_W-1:0]  steps;
   } gteEntry;

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_EXEC = 1'b1
   } seqState_e;

   function automatic gteEntry makeEntry(input logic [ENTRY_AW-1:0] start,
                                         input logic [COUNT_W-1:0] steps);
      gteEntry e;
      e.valid = 1'b1;
      e.start = start;
      e.steps = steps;
      return e;
   endfunction

   // Instructions are packed back to back in the image starting at 1, in
   // ascending funct order; each start is the previous start plus its count.
   function automatic gteEntry entryLookup(input logic [5:0] funct);
      gteEntry e;
      e.valid = 1'b0;
      e.start = NOP_ADDR;
      e.steps = 6'd1;
      case (funct)
         OP_RTPS:  e = makeEntry(9'd1,   CYC_RTPS);
         OP_NCLIP: e = makeEntry(9'd16,  CYC_NCLIP);
         OP_OP:    e = makeEntry(9'd24,  CYC_OP);
         OP_DPCS:  e = makeEntry(9'd30,  CYC_DPCS);
         OP_INTPL: e = makeEntry(9'd38,  CYC_INTPL);
         OP_MVMVA: e = makeEntry(9'd46,  CYC_MVMVA);
         OP_NCDS:  e = makeEntry(9'd54,  CYC_NCDS);
         OP_CDP:   e = makeEntry(9'd73,  CYC_CDP);
         OP_NCDT:  e = makeEntry(9'd86,  CYC_NCDT);
         OP_NCCS:  e = makeEntry(9'd130, CYC_NCCS);
         OP_CC:    e = makeEntry(9'd147, CYC_CC);
         OP_NCS:   e = makeEntry(9'd158, CYC_NCS);
         OP_NCT:   e = makeEntry(9'd172, CYC_NCT);
         OP_SQR:   e = makeEntry(9'd202, CYC_SQR);
         OP_DCPL:  e = makeEntry(9'd207, CYC_DCPL);
         OP_DPCT:  e = makeEntry(9'd215, CYC_DPCT);
         OP_AVSZ3: e = makeEntry(9'd232, CYC_AVSZ3);
         OP_AVSZ4: e = makeEntry(9'd237, CYC_AVSZ4);
         OP_RTPT:  e = makeEntry(9'd243, CYC_RTPT);
         OP_GPF:   e = makeEntry(9'd266, CYC_GPF);
         OP_GPL:   e = makeEntry(9'd271, CYC_GPL);
         OP_NCCT:  e = makeEntry(9'd276, CYC_NCCT);
         default:  e = e;
      endcase
      return e;
   endfunction

   // Image generator: every step of every instruction carries its funct,
   // its step index and a marker on its final step. Unused words are NOP.
   function automatic gteComputeCtrl romWordAt(input int addr);
      gteComputeCtrl w;
      gteEntry       e;
      int            offset;
      w = '0;
      for (int f = 0; f < 64; f++) begin
         e = entryLookup(6'(f));
         offset = addr - int'(e.start);
         if (e.valid && offset >= 0 && offset < int'(e.steps)) begin
            w.valid   = 1'b1;
            w.funct   = 6'(f);
            w.step    = 6'(offset);
            w.finalOp = (offset == int'(e.steps) - 1);
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/gte_instr_sequencer_rom.sv
// ---------------------------------------------------------------------------
// gte_microcode_rom
// Synchronous-read microcode ROM plus the 64-entry funct entry table.
//   i_clk, i_nRst  clock and async active-low reset (clears the read register)
//   i_rdEn         read strobe; when low the output register loads NOP
//   i_addr         microcode address
//   o_data         registered micro-op word
//   i_funct        funct code to look up
//   o_entry        combinational {valid, start, steps} for i_funct
// ---------------------------------------------------------------------------
module gte_microcode_rom
   import GTEDefine::*;
#(
   parameter int UCODE_AW = 9
) (
   input  logic                i_clk,
   input  logic                i_nRst,
   input  logic                i_rdEn,
   input  logic [UCODE_AW-1:0] i_addr,
   output gteComputeCtrl       o_data,
   input  logic [5:0]          i_funct,
   output gteEntry             o_entry
);

   localparam int DEPTH = 2 ** UCODE_AW;

   gteComputeCtrl romArray [DEPTH];
   gteComputeCtrl data_q;
   gteComputeCtrl data_d;

   // The image is computed at elaboration time, one constant per word, so
   // the array reduces to pure constants.
   for (genvar a = 0; a < DEPTH; a++) begin : g_image
      localparam gteComputeCtrl WORD = romWordAt(a);
      assign romArray[a] = WORD;
   end

   // The entry table is read combinationally so the sequencer can form the
   // ROM address in the same cycle the command strobe arrives.
   assign o_entry = entryLookup(i_funct);

   // Without a read request the register drops to NOP, which is what keeps
   // the compute path quiet while the sequencer is idle.
   always_comb begin
      data_d = '0;
      if (i_rdEn) begin
         data_d = romArray[i_addr];
      end
   end

   // Output register of the synchronous ROM.
   always_ff @(posedge i_clk or negedge i_nRst) begin
      if (!i_nRst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign o_data = data_q;

endmodule

// File: rtl/gte_instr_sequencer.sv
// ---------------------------------------------------------------------------
// gte_instr_sequencer
// GTE instruction front-end: latches a COP2 command, decodes its flag fields
// and walks the instruction's microcode, one micro-op per cycle.
//   i_clk, i_nRst   clock and async active-low reset
//   i_run           one-cycle command strobe
//   i_instr         COP2 command bits [24:0]
//   o_instrParam    decoded sf/mx/v/cv/lm, held for the whole command
//   o_computeCtrl   current micro-op, NOP while idle
//   o_busy          command in progress
//   o_lastStep      current micro-op is the final one
//   o_done          one-cycle pulse the cycle after the last step
//   o_illegal       sticky unsupported-funct flag, cleared by the next accept
// ---------------------------------------------------------------------------
module gte_instr_sequencer
   import GTEDefine::*;
#(
   parameter int UCODE_AW = 9
) (
   input  logic          i_clk,
   input  logic          i_nRst,
   input  logic          i_run,
   input  logic [24:0]   i_instr,
   output CTRL           o_instrParam,
   output gteComputeCtrl o_computeCtrl,
   output logic          o_busy,
   output logic          o_lastStep,
   output logic          o_done,
   output logic          o_illegal
);

   seqState_e           state_q, state_d;
   logic [COUNT_W-1:0]  cnt_q, cnt_d;
   logic [UCODE_AW-1:0] addr_q, addr_d;
   logic                lastStep_q, lastStep_d;
   logic                done_q, done_d;
   logic                illegal_q, illegal_d;
   CTRL                 instrParam_q, instrParam_d;

   logic                accept;
   logic                romRdEn;
   logic [UCODE_AW-1:0] romAddr;
   logic [UCODE_AW-1:0] entryAddr;
   gteEntry             entry;
   CTRL                 decoded;
   logic                unusedInstrBits;

   assign unusedInstrBits = ^{i_instr[24:20], i_instr[18:17], i_instr[9:6]};

   assign decoded.sf = i_instr[19];
   assign decoded.mx = i_instr[16:15];
   assign decoded.v  = i_instr[14:13];
   assign decoded.cv = i_instr[12:11];
   assign decoded.lm = i_instr[10];

   assign entryAddr = UCODE_AW'(entry.start);

   // A strobe is taken when idle or on the final step of the running
   // command; anywhere else mid-command it is dropped without side effects.
   assign accept = i_run && ((state_q == SEQ_IDLE) || lastStep_q);

   gte_microcode_rom #(
      .UCODE_AW (UCODE_AW)
   ) u_rom (
      .i_clk   (i_clk),
      .i_nRst  (i_nRst),
      .i_rdEn  (romRdEn),
      .i_addr  (romAddr),
      .o_data  (o_computeCtrl),
      .i_funct (i_instr[5:0]),
      .o_entry (entry)
   );

   // Next-state logic. The ROM is read one cycle ahead of its output, so on
   // accept the start address goes straight to the ROM and addr_q is left
   // pointing at the following step. An accept on the last step overrides
   // the return to idle but keeps the done pulse of the finishing command.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      lastStep_d   = lastStep_q;
      done_d       = 1'b0;
      illegal_d    = illegal_q;
      instrParam_d = instrParam_q;
      romRdEn      = 1'b0;
      romAddr      = addr_q;

      case (state_q)
         SEQ_IDLE: begin
            lastStep_d = 1'b0;
         end
         SEQ_EXEC: begin
            if (lastStep_q) begin
               state_d    = SEQ_IDLE;
               lastStep_d = 1'b0;
               done_d     = 1'b1;
            end else begin
               cnt_d      = cnt_q - COUNT_W'(1);
               lastStep_d = (cnt_q == COUNT_W'(1));
               addr_d     = addr_q + UCODE_AW'(1);
               romRdEn    = 1'b1;
            end
         end
         default: begin
            state_d = SEQ_IDLE;
         end
      endcase

      if (accept) begin
         state_d      = SEQ_EXEC;
         cnt_d        = entry.steps - COUNT_W'(1);
         lastStep_d   = (entry.steps == COUNT_W'(1));
         addr_d       = entryAddr + UCODE_AW'(1);
         romAddr      = entryAddr;
         romRdEn      = 1'b1;
         illegal_d    = !entry.valid;
         instrParam_d = decoded;
      end
   end

   // All sequencer state and registered outputs live in this one block;
   // reset abandons any command in flight without a done pulse.
   always_ff @(posedge i_clk or negedge i_nRst) begin
      if (!i_nRst) begin
         state_q      <= SEQ_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         lastStep_q   <= 1'b0;
         done_q       <= 1'b0;
         illegal_q    <= 1'b0;
         instrParam_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         lastStep_q   <= lastStep_d;
         done_q       <= done_d;
         illegal_q    <= illegal_d;
         instrParam_q <= instrParam_d;
      end
   end

   assign o_busy       = (state_q == SEQ_EXEC);
   assign o_lastStep   = lastStep_q;
   assign o_done       = done_q;
   assign o_illegal    = illegal_q;
   assign o_instrParam = instrParam_q;

endmodule

// File: tb/tb_gte_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gte_instr_sequencer
// Self-checking bench for gte_instr_sequencer: a command-level model predicts
// every output each cycle; a vector table and directed sequences add
// whole-command checks on cycle counts, done pulses and decoded fields.
// ---------------------------------------------------------------------------
module tb_gte_instr_sequencer;
   import GTEDefine::*;

   logic        clk = 1'b0;
   logic        nRst;
   logic        run;
   logic [24:0] instr;
   logic [$bits(CTRL)-1:0]           instrParam;
   logic [$bits(gteComputeCtrl)-1:0] computeCtrl;
   logic        busy;
   logic        lastStep;
   logic        done;
   logic        illegal;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Model of the command currently (or most recently) running.
   bit         curValid   = 1'b0;
   bit         curLegal   = 1'b0;
   int         curStart   = 0;
   int         curLast    = 0;
   logic [5:0] curFunct   = '0;
   logic [7:0] expParam   = '0;
   bit         expIllegal = 1'b0;
   int         doneQ[$];

   // Observations gathered per test section.
   int busyCount;
   int doneCount;
   int lastStepCycle;
   int doneSeen[$];

   typedef struct {
      logic [24:0] instr;
      int          expN;
      logic [7:0]  expParam;
      bit          expIllegal;
   } vec_t;

   logic [5:0] legalFuncts [22] = '{6'h01, 6'h06, 6'h0C, 6'h10, 6'h11, 6'h12,
                                    6'h13, 6'h14, 6'h16, 6'h1B, 6'h1C, 6'h1E,
                                    6'h20, 6'h28, 6'h29, 6'h2A, 6'h2D, 6'h2E,
                                    6'h30, 6'h3D, 6'h3E, 6'h3F};

   gte_instr_sequencer #(
      .UCODE_AW (9)
   ) dut (
      .i_clk         (clk),
      .i_nRst        (nRst),
      .i_run         (run),
      .i_instr       (instr),
      .o_instrParam  (instrParam),
      .o_computeCtrl (computeCtrl),
      .o_busy        (busy),
      .o_lastStep    (lastStep),
      .o_done        (done),
      .o_illegal     (illegal)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Documented cycle count per funct; 0 marks an unsupported funct.
   function automatic int expSteps(input logic [5:0] f);
      case (f)
         6'h01: return 15;  6'h06: return 8;   6'h0C: return 6;
         6'h10: return 8;   6'h11: return 8;   6'h12: return 8;
         6'h13: return 19;  6'h14: return 13;  6'h16: return 44;
         6'h1B: return 17;  6'h1C: return 11;  6'h1E: return 14;
         6'h20: return 30;  6'h28: return 5;   6'h29: return 8;
         6'h2A: return 17;  6'h2D: return 5;   6'h2E: return 6;
         6'h30: return 23;  6'h3D: return 5;   6'h3E: return 5;
         6'h3F: return 39;
         default: return 0;
      endcase
   endfunction

   // Field decode as {sf, mx, v, cv, lm}.
   function automatic logic [7:0] expParamOf(input logic [24:0] w);
      return {w[19], w[16:15], w[14:13], w[12:11], w[10]};
   endfunction

   function automatic bit modelBusy(input int c);
      return curValid && (c >= curStart) && (c <= curLast);
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Compare every output against the model for the current cycle.
   task automatic checkOutput();
      bit busyE;
      bit lastE;
      bit doneE;
      logic [$bits(gteComputeCtrl)-1:0] ctrlE;
      busyE = modelBusy(cyc);
      lastE = busyE && (cyc == curLast);
      doneE = 1'b0;
      foreach (doneQ[i]) if (doneQ[i] == cyc) doneE = 1'b1;
      ctrlE = '0;
      if (busyE && curLegal) ctrlE = {1'b1, curFunct, 6'(cyc - curStart), lastE};
      checkVal("busy",        32'(busy),        32'(busyE));
      checkVal("lastStep",    32'(lastStep),    32'(lastE));
      checkVal("done",        32'(done),        32'(doneE));
      checkVal("computeCtrl", 32'(computeCtrl), 32'(ctrlE));
      checkVal("instrParam",  32'(instrParam),  32'(expParam));
      checkVal("illegal",     32'(illegal),     32'(expIllegal));
      if (busy === 1'b1) busyCount++;
      if (done === 1'b1) begin
         doneCount++;
         doneSeen.push_back(cyc);
      end
      if (lastStep === 1'b1) lastStepCycle = cyc;
   endtask

   // Drive one cycle of inputs, update the model, advance and check.
   task automatic applyStimulus(input bit doRun, input logic [24:0] w);
      int n;
      run   = doRun;
      instr = w;
      if (doRun && (!modelBusy(cyc) || cyc == curLast)) begin
         n          = expSteps(w[5:0]);
         curLegal   = (n != 0);
         if (!curLegal) n = 1;
         curValid   = 1'b1;
         curStart   = cyc + 1;
         curLast    = cyc + n;
         curFunct   = w[5:0];
         expParam   = expParamOf(w);
         expIllegal = !curLegal;
         doneQ.push_back(cyc + n + 1);
      end
      @(posedge clk);
      cyc++;
      #1;
      run = 1'b0;
      checkOutput();
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 25'($urandom));
   endtask

   task automatic clearCounts();
      busyCount     = 0;
      doneCount     = 0;
      lastStepCycle = -1;
      doneSeen.delete();
   endtask

   function automatic int doneOffset(input int idx, input int t);
      if (doneSeen.size() > idx) return doneSeen[idx] - t;
      return -1;
   endfunction

   // Asynchronous reset between clock edges; outputs must clear at once.
   task automatic asyncReset();
      #2;
      nRst = 1'b0;
      #1;
      checkVal("rstBusy",        32'(busy),        32'd0);
      checkVal("rstLastStep",    32'(lastStep),    32'd0);
      checkVal("rstDone",        32'(done),        32'd0);
      checkVal("rstComputeCtrl", 32'(computeCtrl), 32'd0);
      checkVal("rstInstrParam",  32'(instrParam),  32'd0);
      checkVal("rstIllegal",     32'(illegal),     32'd0);
      curValid   = 1'b0;
      curLegal   = 1'b0;
      expParam   = '0;
      expIllegal = 1'b0;
      doneQ.delete();
      #1;
      nRst = 1'b1;
   endtask

   // Hard time limit so the bench always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs [8];
      int   t;
      logic [24:0] w;
      logic [5:0]  f;

      vecs[0] = '{25'h0080001, 15, 8'h80, 1'b0};
      vecs[1] = '{25'h04A6012,  8, 8'h98, 1'b0};
      vecs[2] = '{25'h0000000,  1, 8'h00, 1'b1};
      vecs[3] = '{25'h1400006,  8, 8'h00, 1'b0};
      vecs[4] = '{25'h019043D,  5, 8'hC1, 1'b0};
      vecs[5] = '{25'h0007C2E,  6, 8'h1F, 1'b0};
      vecs[6] = '{25'h0000007,  1, 8'h00, 1'b1};
      vecs[7] = '{25'h008043F, 39, 8'h81, 1'b0};

      nRst  = 1'b0;
      run   = 1'b0;
      instr = '0;
      repeat (2) @(posedge clk);
      #1;
      checkVal("resetBusy",        32'(busy),        32'd0);
      checkVal("resetLastStep",    32'(lastStep),    32'd0);
      checkVal("resetDone",        32'(done),        32'd0);
      checkVal("resetComputeCtrl", 32'(computeCtrl), 32'd0);
      checkVal("resetInstrParam",  32'(instrParam),  32'd0);
      checkVal("resetIllegal",     32'(illegal),     32'd0);
      #4;
      nRst = 1'b1;
      idle(2);

      $display("[TB] vector table");
      for (int i = 0; i < 8; i++) begin
         clearCounts();
         t = cyc;
         applyStimulus(1'b1, vecs[i].instr);
         idle(vecs[i].expN + 2);
         checkVal("vecBusyCycles", busyCount, vecs[i].expN);
         checkVal("vecLastStepAt", lastStepCycle - t, vecs[i].expN);
         checkVal("vecDoneCount", doneCount, 1);
         checkVal("vecDoneAt", doneOffset(0, t), vecs[i].expN + 1);
         checkVal("vecParam", 32'(instrParam), 32'(vecs[i].expParam));
         checkVal("vecIllegal", 32'(illegal), 32'(vecs[i].expIllegal));
      end

      $display("[TB] back-to-back SQR then AVSZ3");
      clearCounts();
      t = cyc;
      applyStimulus(1'b1, 25'h0000028);
      idle(4);
      applyStimulus(1'b1, 25'h008002D);
      idle(7);
      checkVal("b2bBusyCycles", busyCount, 10);
      checkVal("b2bDoneCount", doneCount, 2);
      checkVal("b2bFirstDoneAt", doneOffset(0, t), 6);
      checkVal("b2bSecondDoneAt", doneOffset(1, t), 11);
      checkVal("b2bParam", 32'(instrParam), 32'h80);

      $display("[TB] ignored run during NCDT");
      clearCounts();
      t = cyc;
      applyStimulus(1'b1, 25'h0000416);
      idle(10);
      applyStimulus(1'b1, 25'h0080001);
      idle(36);
      checkVal("ignBusyCycles", busyCount, 44);
      checkVal("ignDoneCount", doneCount, 1);
      checkVal("ignDoneAt", doneOffset(0, t), 45);
      checkVal("ignParam", 32'(instrParam), 32'h01);

      $display("[TB] async reset at step 7 of NCT");
      t = cyc;
      applyStimulus(1'b1, 25'h0006420);
      idle(7);
      checkVal("nctParamBeforeReset", 32'(instrParam), 32'h19);
      asyncReset();
      clearCounts();
      idle(35);
      checkVal("postRstDoneCount", doneCount, 0);
      checkVal("postRstBusyCycles", busyCount, 0);
      clearCounts();
      t = cyc;
      applyStimulus(1'b1, 25'h0080001);
      idle(17);
      checkVal("postRstRtpsBusy", busyCount, 15);
      checkVal("postRstRtpsDoneAt", doneOffset(0, t), 16);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         w = 25'($urandom);
         if ($urandom_range(0, 3) != 0) f = legalFuncts[$urandom_range(0, 21)];
         else f = 6'($urandom);
         w[5:0] = f;
         applyStimulus($urandom_range(0, 2) == 0, w);
      end
      idle(50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
